// File: rtl/uart_pkg.sv
// Shared definitions for the UART engine: parity modes, FSM state
// encodings and the FIFO level width helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // A level counter needs one more bit than a pointer so "full" is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and a separate
// occupancy counter; pointers wrap naturally because DEPTH is a power of 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_pop  = rd_en && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
    assign do_push = wr_en && (!full || rd_en);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// UART engine: FIFO-buffered TX serializer and RX deserializer with
// configurable frame format, parity and sticky receive error flags.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_we,
    output logic                            tx_full,
    output logic [lvl_w(FIFO_DEPTH)-1:0]    tx_level,
    output logic                            tx_busy,
    output logic [DATA_BITS-1:0]            rx_data,
    input  logic                            rx_re,
    output logic                            rx_empty,
    output logic [lvl_w(FIFO_DEPTH)-1:0]    rx_level,
    input  logic                            err_clr,
    output logic                            rx_overrun,
    output logic                            rx_parity_err,
    output logic                            rx_frame_err,
    output logic                            uart_txd,
    input  logic                            uart_rxd
);

    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID       = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == PARITY_ODD);

    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty;
    logic                 tx_pop;
    logic                 rx_full;
    logic                 rx_push;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_we),
        .wr_data (tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_stop_done;

    assign tx_stop_done = (tx_state == TX_STOP) && (tx_cnt == STOP_LAST);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign tx_pop = !tx_empty && ((tx_state == TX_IDLE) || tx_stop_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_shift <= tx_head;
            tx_par   <= (^tx_head) ^ PAR_ODD;
            uart_txd <= 1'b0;
            tx_busy  <= 1'b1;
        end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx != IDX_LAST) begin
                            tx_idx   <= tx_idx + IDX_W'(1);
                            uart_txd <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end else if (PARITY != PARITY_NONE) begin
                            tx_state <= TX_PARITY;
                            uart_txd <= tx_par;
                        end else begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= TX_STOP;
                        tx_cnt   <= '0;
                        uart_txd <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_stop_done) begin
                        tx_state <= TX_IDLE;
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    logic rxd_meta;
    logic rxd_sync;
    logic rxd_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_stop_sample;
    logic                 rx_par_ok;

    assign rx_stop_sample = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign rx_par_ok      = (PARITY == PARITY_NONE) ||
                            (rx_par_bit == ((^rx_shift) ^ PAR_ODD));
    assign rx_push        = rx_stop_sample && rxd_sync && rx_par_ok;

    // The edge-detect cycle counts as 0, so START samples CLKS_PER_BIT/2 cycles into the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= CNT_W'(1);
                    end
                end
                RX_START: begin
                    if (rx_cnt == MID) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx != IDX_LAST) begin
                            rx_idx <= rx_idx + IDX_W'(1);
                        end else if (PARITY != PARITY_NONE) begin
                            rx_state <= RX_PARITY;
                        end else begin
                            rx_state <= RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bit <= rxd_sync;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_stop_sample) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (rx_shift),
        .rd_en   (rx_re),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    // A new error outranks err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (rx_stop_sample && !rxd_sync)
                rx_frame_err <= 1'b1;
            else if (err_clr)
                rx_frame_err <= 1'b0;

            if (rx_stop_sample && rxd_sync && !rx_par_ok)
                rx_parity_err <= 1'b1;
            else if (err_clr)
                rx_parity_err <= 1'b0;

            if (rx_push && rx_full && !rx_re)
                rx_overrun <= 1'b1;
            else if (err_clr)
                rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: one core without parity (TX timing, burst, loopback) and one
// with even parity whose serial input is driven frame by frame.
module tb_uart_fifo_core;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          err_clr;
    logic          loop_en;

    logic [7:0]    tx_data;
    logic          tx_we;
    logic          tx_full;
    logic [LW-1:0] tx_level;
    logic          tx_busy;
    logic [7:0]    rx_data;
    logic          rx_re;
    logic          rx_empty;
    logic [LW-1:0] rx_level;
    logic          rx_overrun, rx_parity_err, rx_frame_err;
    logic          uart_txd, uart_rxd;

    logic [7:0]    tx_data_p;
    logic          tx_we_p;
    logic          tx_full_p;
    logic [LW-1:0] tx_level_p;
    logic          tx_busy_p;
    logic [7:0]    rx_data_p;
    logic          rx_re_p;
    logic          rx_empty_p;
    logic [LW-1:0] rx_level_p;
    logic          rx_overrun_p, rx_parity_err_p, rx_frame_err_p;
    logic          uart_txd_p, rxd_p;

    assign uart_rxd = loop_en ? uart_txd : 1'b1;

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_we(tx_we), .tx_full(tx_full),
        .tx_level(tx_level), .tx_busy(tx_busy), .rx_data(rx_data), .rx_re(rx_re),
        .rx_empty(rx_empty), .rx_level(rx_level), .err_clr(err_clr),
        .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    uart_fifo_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_we(tx_we_p), .tx_full(tx_full_p),
        .tx_level(tx_level_p), .tx_busy(tx_busy_p), .rx_data(rx_data_p), .rx_re(rx_re_p),
        .rx_empty(rx_empty_p), .rx_level(rx_level_p), .err_clr(err_clr),
        .rx_overrun(rx_overrun_p), .rx_parity_err(rx_parity_err_p),
        .rx_frame_err(rx_frame_err_p), .uart_txd(uart_txd_p), .uart_rxd(rxd_p)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cycles;
        logic txd;
        logic busy;
    } seg_t;

    typedef struct {
        logic       re;
        logic [7:0] data;
        int         level;
        logic       empty;
    } rxv_t;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic re);
        rx_re = re;
        @(negedge clk);
        rx_re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // start, 8 data bits LSB first, parity, stop; then idle high
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_p = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rxd_p = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    // Expected uart_txd, one sample per cycle, for a no-parity 8N1 frame.
    function automatic logic [39:0] frame_exp(input logic [7:0] d);
        logic [39:0] f;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       f[i] = 1'b0;
            else if (i < 36) f[i] = d[(i - 4) / 4];
            else             f[i] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [7:0] burst_word(input int k);
        return 8'(k * 37 + 11);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        seg_t       segs[$];
        rxv_t       rxv[$];
        logic       cap [700];
        logic [7:0] a5;
        logic [7:0] first_p;
        logic [7:0] d;

        rst = 1'b1; err_clr = 1'b0; loop_en = 1'b0;
        tx_data = '0; tx_we = 1'b0; rx_re = 1'b0;
        tx_data_p = '0; tx_we_p = 1'b0; rx_re_p = 1'b0; rxd_p = 1'b1;

        a5 = 8'hA5;
        segs.push_back('{1, 1'b1, 1'b0});
        segs.push_back('{CPB, 1'b0, 1'b1});
        for (int b = 0; b < 8; b++) segs.push_back('{CPB, a5[b], 1'b1});
        segs.push_back('{CPB, 1'b1, 1'b1});
        segs.push_back('{2, 1'b1, 1'b0});

        rxv.push_back('{1'b0, 8'h00, 3, 1'b0});
        rxv.push_back('{1'b1, 8'hFF, 2, 1'b0});
        rxv.push_back('{1'b1, 8'h3C, 1, 1'b0});
        rxv.push_back('{1'b1, 8'h00, 0, 1'b1});
        rxv.push_back('{1'b1, 8'h00, 0, 1'b1});

        repeat (2) @(negedge clk);
        checkOutput("reset txd", uart_txd, 1);
        checkOutput("reset tx_busy", tx_busy, 0);
        checkOutput("reset tx_level", tx_level, 0);
        checkOutput("reset tx_full", tx_full, 0);
        checkOutput("reset rx_empty", rx_empty, 1);
        checkOutput("reset rx_level", rx_level, 0);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset flags", {rx_overrun, rx_parity_err, rx_frame_err}, 0);
        checkOutput("reset rx_empty_p", rx_empty_p, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single 0xA5 frame, cycle-exact
        tx_data = 8'hA5; tx_we = 1'b1;
        @(negedge clk);
        tx_we = 1'b0;
        foreach (segs[i]) begin
            for (int c = 0; c < segs[i].cycles; c++) begin
                checkOutput($sformatf("tx seg%0d txd", i), uart_txd, segs[i].txd);
                checkOutput($sformatf("tx seg%0d busy", i), tx_busy, segs[i].busy);
                @(negedge clk);
            end
        end

        // Reset in the middle of a frame
        tx_data = 8'h00; tx_we = 1'b1;
        @(negedge clk);
        tx_we = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midframe txd low", uart_txd, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midframe reset txd", uart_txd, 1);
        checkOutput("midframe reset busy", tx_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Burst of 18 writes: one taken straight away, 16 buffered, the last dropped
        for (int c = 0; c < 700; c++) begin
            cap[c] = uart_txd;
            if (c == 18) begin
                checkOutput("burst tx_full", tx_full, 1);
                checkOutput("burst tx_level", tx_level, DEPTH);
            end
            if (c < 18) begin
                tx_we = 1'b1;
                tx_data = burst_word(c);
            end else begin
                tx_we = 1'b0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 17; k++) begin
            logic [39:0] got;
            for (int j = 0; j < 40; j++) got[j] = cap[2 + 40 * k + j];
            checkOutput($sformatf("burst frame%0d", k), got, frame_exp(burst_word(k)));
        end
        begin
            logic [17:0] idle_got;
            for (int j = 0; j < 18; j++) idle_got[j] = cap[682 + j];
            checkOutput("burst idle after last", idle_got, 18'h3FFFF);
        end
        checkOutput("burst tx_busy end", tx_busy, 0);

        // Loopback of three words through the RX path
        do_reset();
        loop_en = 1'b1;
        tx_we = 1'b1; tx_data = 8'h00; @(negedge clk);
        tx_data = 8'hFF; @(negedge clk);
        tx_data = 8'h3C; @(negedge clk);
        tx_we = 1'b0;
        repeat (150) @(negedge clk);
        foreach (rxv[i]) begin
            if (i > 0) applyStimulus(rxv[i].re);
            checkOutput($sformatf("loop%0d rx_data", i), rx_data, rxv[i].data);
            checkOutput($sformatf("loop%0d rx_level", i), rx_level, rxv[i].level);
            checkOutput($sformatf("loop%0d rx_empty", i), rx_empty, rxv[i].empty);
        end
        checkOutput("loop flags", {rx_overrun, rx_parity_err, rx_frame_err}, 0);
        loop_en = 1'b0;

        // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong
        do_reset();
        send_frame(8'h07, 1'b0, 1'b1);
        checkOutput("parity err set", rx_parity_err_p, 1);
        checkOutput("parity err no push", rx_level_p, 0);
        checkOutput("parity err no frame err", rx_frame_err_p, 0);
        pulse_clr();
        checkOutput("parity err cleared", rx_parity_err_p, 0);

        send_frame(8'h55, 1'b0, 1'b0);
        checkOutput("frame err set", rx_frame_err_p, 1);
        checkOutput("frame err beats parity", rx_parity_err_p, 0);
        checkOutput("frame err no push", rx_level_p, 0);
        pulse_clr();
        checkOutput("frame err cleared", rx_frame_err_p, 0);

        rxd_p = 1'b0;
        @(negedge clk);
        rxd_p = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("glitch flags", {rx_overrun_p, rx_parity_err_p, rx_frame_err_p}, 0);
        checkOutput("glitch no push", rx_level_p, 0);

        send_frame(8'h07, 1'b1, 1'b1);
        checkOutput("good frame level", rx_level_p, 1);
        checkOutput("good frame data", rx_data_p, 8'h07);

        // Fill to 16, then one more frame overruns
        first_p = 8'h00;
        for (int i = 0; i < 15; i++) begin
            d = 8'(i * 19 + 3);
            if (i == 0) first_p = d;
            send_frame(d, ^d, 1'b1);
        end
        checkOutput("fill level", rx_level_p, DEPTH);
        checkOutput("fill no overrun", rx_overrun_p, 0);
        send_frame(8'hEE, ^8'hEE, 1'b1);
        checkOutput("overrun set", rx_overrun_p, 1);
        checkOutput("overrun level", rx_level_p, DEPTH);
        checkOutput("overrun head", rx_data_p, 8'h07);
        rx_re_p = 1'b1;
        @(negedge clk);
        rx_re_p = 1'b0;
        checkOutput("overrun next head", rx_data_p, first_p);
        checkOutput("overrun after pop level", rx_level_p, DEPTH - 1);
        pulse_clr();
        checkOutput("overrun cleared", rx_overrun_p, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
